retire_trace_unit: RTL and testbench
====================================

RETIRE_TRACE_UNIT -- requirements
Module: retire_trace_unit

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-002 Parameter TOHOST_ADDR, default 32'h1000_0000, DCCM write address signalling end of test.
REQ-003 Parameter WDOG_LIMIT, default 1000, idle cycles before hang is flagged.
REQ-004 clk  input  1  core clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wb_valid_i  input  1  register-file writeback retiring this cycle.
REQ-007 wb_tag_i  input  XLEN  PC tag of the retiring instruction.
REQ-008 wb_instr_i  input  32  retiring instruction word.
REQ-009 wb_rd_i  input  5  destination register.
REQ-010 wb_data_i  input  XLEN  writeback data.
REQ-011 wb_pc_load_i  input  1  retiring instruction redirected the PC.
REQ-012 wb_pc_i  input  XLEN  redirect target; meaningful only with wb_pc_load_i.
REQ-013 st_valid_i  input  1  store retiring this cycle.
REQ-014 st_tag_i / st_instr_i / st_addr_i / st_data_i  input  XLEN/32/XLEN/XLEN  store tag, instruction, address, masked data.
REQ-015 dccm_wen_i / dccm_waddr_i  input  1/XLEN  raw DCCM write strobe and address.
REQ-016 trc_valid_o  output  1  trace record available.
REQ-017 trc_ready_i  input  1  consumer accepts the record.
REQ-018 trc_rec_o  output  trace_rec_t  head-of-FIFO record.
REQ-019 overflow_o / drop_cnt_o  output  1/16  sticky overflow flag; saturating dropped-record count.
REQ-020 finish_o / hang_o / cycle_cnt_o  output  1/1/32  end-of-test, watchdog hang, free-running cycle count.

Function
REQ-021 cycle_cnt_o increments by 1 every cycle after reset and wraps 0xFFFF_FFFF -> 0.
REQ-022 A record is formed in every cycle where wb_valid_i | st_valid_i; its fields are the cycle stamp (cycle_cnt_o value in that cycle), a kind mask {pc_load, st, wb}, and all wb_* and st_* fields. Fields of absent kinds are zero.
REQ-023 The record is pushed in the same cycle; the earliest trc_valid_o is the next cycle (1-cycle latency); records leave in push order.
REQ-024 A pop occurs when trc_valid_o & trc_ready_i; trc_rec_o is stable while trc_valid_o=1 and trc_ready_i=0.
REQ-025 When the FIFO is full, a simultaneous push and pop both succeed; a push without a pop is dropped, overflow_o is set (sticky), and drop_cnt_o increments, saturating at 0xFFFF.
REQ-026 trc_valid_o=0 when the FIFO is empty; a push into an empty FIFO is not bypassed to the output in the same cycle.
REQ-027 tohost_seen sets (sticky) on dccm_wen_i & dccm_waddr_i==TOHOST_ADDR.
REQ-028 finish_o asserts in the first cycle in which tohost_seen=1 and the FIFO is empty, then stays high; records pushed after tohost_seen is set are still queued.
REQ-029 Idle counter: cleared to 0 on any record-forming cycle; otherwise increments, saturating at WDOG_LIMIT+1.

Reset
REQ-030 rst_n low clears asynchronously: FIFO pointers, trc_valid_o, overflow_o, drop_cnt_o, finish_o, hang_o, cycle_cnt_o, tohost_seen and the idle counter, all to 0; trc_rec_o is don't-care while empty.
REQ-031 Reset asserted mid-operation discards queued records with no partial output.

Configuration
REQ-032 Macro RETIRE_TRACE_WATCHDOG_EN defined: hang_o sets (sticky) once the idle counter exceeds WDOG_LIMIT and finish_o=0.
REQ-033 RETIRE_TRACE_WATCHDOG_EN undefined: no idle counter is built and hang_o is tied to 0.

Structure
REQ-034 Package trace_pkg holds trace_rec_t, the kind-bit index constants, and the TOHOST_ADDR default; XLEN comes from the global package.
REQ-035 FIFO storage and pointers sit in the sub-module trace_fifo (synchronous, DEPTH-parameterised, full/empty, push/pop).

Verification
REQ-036 wb_valid_i=1, rd=5, data=0xDEAD_BEEF in cycle 20 -> in cycle 21, trc_valid_o=1, stamp=20, kind=3'b001, rd=5.
REQ-037 wb and st together with pc_load=1, pc=0x80 -> one record, kind=3'b111, pc field=0x80.
REQ-038 trc_ready_i=0, 20 events, DEPTH=16 -> 16 records kept, drop_cnt_o=4, overflow_o=1; draining returns stamps in order.
REQ-039 FIFO full, push and pop in the same cycle -> no drop; occupancy stays 16.
REQ-040 DCCM write to 0x1000_0000 with 3 records queued -> finish_o rises only in the cycle after the last pop.
REQ-041 With the watchdog enabled, no events for 1001 cycles -> hang_o=1; rst_n pulsed mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide configuration shared by the pipeline and its observers.
package core_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/trace_pkg.sv
// Retire trace record layout, kind-mask bit positions and tohost default.
package trace_pkg;
    import core_pkg::*;

    localparam int KIND_WB  = 0;
    localparam int KIND_ST  = 1;
    localparam int KIND_PCL = 2;

    localparam logic [XLEN-1:0] TOHOST_ADDR_DEF = 32'h1000_0000;

    typedef struct packed {
        logic [31:0]     stamp;
        logic [2:0]      kind;
        logic [XLEN-1:0] wb_tag;
        logic [31:0]     wb_instr;
        logic [4:0]      wb_rd;
        logic [XLEN-1:0] wb_data;
        logic [XLEN-1:0] wb_pc;
        logic [XLEN-1:0] st_tag;
        logic [31:0]     st_instr;
        logic [XLEN-1:0] st_addr;
        logic [XLEN-1:0] st_data;
    } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous power-of-two FIFO; a push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/retire_trace_unit.sv
// Captures retiring writebacks/stores into a trace FIFO, detects tohost end-of-test.
// Define RETIRE_TRACE_WATCHDOG_EN to build the idle watchdog driving hang_o.
module retire_trace_unit
    import core_pkg::*, trace_pkg::*;
#(
    parameter int              DEPTH       = 16,
    parameter logic [XLEN-1:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter int              WDOG_LIMIT  = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_tag_i,
    input  logic [31:0]     wb_instr_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            wb_pc_load_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            st_valid_i,
    input  logic [XLEN-1:0] st_tag_i,
    input  logic [31:0]     st_instr_i,
    input  logic [XLEN-1:0] st_addr_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic            dccm_wen_i,
    input  logic [XLEN-1:0] dccm_waddr_i,
    output logic            trc_valid_o,
    input  logic            trc_ready_i,
    output trace_rec_t      trc_rec_o,
    output logic            overflow_o,
    output logic [15:0]     drop_cnt_o,
    output logic            finish_o,
    output logic            hang_o,
    output logic [31:0]     cycle_cnt_o
);
    trace_rec_t rec;
    logic       push, pop, full, empty, drop;
    logic       tohost_seen, finish_q;

    assign push = wb_valid_i | st_valid_i;
    assign pop  = trc_valid_o & trc_ready_i;
    assign drop = push & full & ~pop;

    always_comb begin
        rec                = '0;
        rec.stamp          = cycle_cnt_o;
        rec.kind[KIND_WB]  = wb_valid_i;
        rec.kind[KIND_ST]  = st_valid_i;
        rec.kind[KIND_PCL] = wb_valid_i & wb_pc_load_i;
        if (wb_valid_i) begin
            rec.wb_tag   = wb_tag_i;
            rec.wb_instr = wb_instr_i;
            rec.wb_rd    = wb_rd_i;
            rec.wb_data  = wb_data_i;
            if (wb_pc_load_i) rec.wb_pc = wb_pc_i;
        end
        if (st_valid_i) begin
            rec.st_tag   = st_tag_i;
            rec.st_instr = st_instr_i;
            rec.st_addr  = st_addr_i;
            rec.st_data  = st_data_i;
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .W($bits(trace_rec_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rec),
        .dout  (trc_rec_o),
        .full  (full),
        .empty (empty)
    );

    assign trc_valid_o = ~empty;
    // Finish may only rise once everything queued before it has drained.
    assign finish_o    = finish_q | (tohost_seen & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_o <= '0;
            overflow_o  <= 1'b0;
            drop_cnt_o  <= '0;
            tohost_seen <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
            finish_q    <= finish_o;
            if (dccm_wen_i && dccm_waddr_i == TOHOST_ADDR) tohost_seen <= 1'b1;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

`ifdef RETIRE_TRACE_WATCHDOG_EN
    localparam int IW = $clog2(WDOG_LIMIT + 2);
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            hang_o   <= 1'b0;
        end else begin
            if (push)                               idle_cnt <= '0;
            else if (idle_cnt != IW'(WDOG_LIMIT + 1)) idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt > IW'(WDOG_LIMIT) && !finish_o) hang_o <= 1'b1;
        end
    end
`else
    assign hang_o = 1'b0;
`endif
endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit with hand-computed expectations.
module tb_retire_trace_unit;
    import core_pkg::*;
    import trace_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_valid_i, wb_pc_load_i, st_valid_i, dccm_wen_i, trc_ready_i;
    logic [XLEN-1:0] wb_tag_i, wb_data_i, wb_pc_i, st_tag_i, st_addr_i, st_data_i, dccm_waddr_i;
    logic [31:0]     wb_instr_i, st_instr_i;
    logic [4:0]      wb_rd_i;
    logic            trc_valid_o, overflow_o, finish_o, hang_o;
    trace_rec_t      trc_rec_o;
    logic [15:0]     drop_cnt_o;
    logic [31:0]     cycle_cnt_o;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_stamp [16];

    retire_trace_unit dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_instr_i(wb_instr_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_pc_load_i(wb_pc_load_i),
        .wb_pc_i(wb_pc_i), .st_valid_i(st_valid_i), .st_tag_i(st_tag_i),
        .st_instr_i(st_instr_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .dccm_wen_i(dccm_wen_i), .dccm_waddr_i(dccm_waddr_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_rec_o(trc_rec_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .finish_o(finish_o),
        .hang_o(hang_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        wb_valid_i = 0; wb_pc_load_i = 0; st_valid_i = 0; dccm_wen_i = 0;
        wb_tag_i = 0; wb_data_i = 0; wb_pc_i = 0; wb_instr_i = 0; wb_rd_i = 0;
        st_tag_i = 0; st_addr_i = 0; st_data_i = 0; st_instr_i = 0; dccm_waddr_i = 0;
    endtask

    task automatic wait_cyc(input logic [31:0] c);
        for (int i = 0; i < 3000 && cycle_cnt_o != c; i++) tick();
        chk("wait_cyc", cycle_cnt_o, c);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_valid"}, trc_valid_o, 0);
        chk({tag, "_ovf"},   overflow_o, 0);
        chk({tag, "_drop"},  drop_cnt_o, 0);
        chk({tag, "_fin"},   finish_o, 0);
        chk({tag, "_hang"},  hang_o, 0);
        chk({tag, "_cyc"},   cycle_cnt_o, 0);
    endtask

    initial begin
        clr_in();
        trc_ready_i = 0;
        #12;
        chk_zero_outs("rst");
        @(negedge clk);
        rst_n = 1;

        // single writeback, 1-cycle latency, no bypass into empty FIFO
        wait_cyc(20);
        wb_valid_i = 1; wb_rd_i = 5; wb_data_i = 32'hDEAD_BEEF; wb_tag_i = 32'h100;
        wb_instr_i = 32'h13;
        #1 chk("nobypass", trc_valid_o, 0);
        tick();
        clr_in();
        chk("t1_valid", trc_valid_o, 1);
        chk("t1_stamp", trc_rec_o.stamp, 20);
        chk("t1_kind",  trc_rec_o.kind, 3'b001);
        chk("t1_rd",    trc_rec_o.wb_rd, 5);
        chk("t1_data",  trc_rec_o.wb_data, 32'hDEAD_BEEF);
        chk("t1_tag",   trc_rec_o.wb_tag, 32'h100);
        chk("t1_pc",    trc_rec_o.wb_pc, 0);
        chk("t1_staddr", trc_rec_o.st_addr, 0);
        trc_ready_i = 1; tick(); trc_ready_i = 0;
        chk("t1_empty", trc_valid_o, 0);

        // non-matching DCCM address must not finish
        dccm_wen_i = 1; dccm_waddr_i = 32'h1000_0004;
        tick(); clr_in(); tick();
        chk("badaddr_fin", finish_o, 0);

        // combined wb + st + redirect
        wb_valid_i = 1; st_valid_i = 1; wb_pc_load_i = 1; wb_pc_i = 32'h80;
        wb_rd_i = 1; wb_data_i = 7; st_addr_i = 32'h200; st_data_i = 32'h55;
        tick(); clr_in();
        chk("t2_kind",  trc_rec_o.kind, 3'b111);
        chk("t2_pc",    trc_rec_o.wb_pc, 32'h80);
        chk("t2_rd",    trc_rec_o.wb_rd, 1);
        chk("t2_stadr", trc_rec_o.st_addr, 32'h200);
        chk("t2_stdat", trc_rec_o.st_data, 32'h55);
        trc_ready_i = 1; tick(); trc_ready_i = 0;
        chk("t2_one", trc_valid_o, 0);

        // overflow: 20 events into DEPTH=16 with consumer stalled
        wait_cyc(100);
        for (int i = 0; i < 20; i++) begin
            wb_valid_i = 1; wb_rd_i = 5'(i);
            tick();
        end
        clr_in();
        chk("t3_drop",  drop_cnt_o, 4);
        chk("t3_ovf",   overflow_o, 1);
        chk("t3_valid", trc_valid_o, 1);
        chk("t3_head",  trc_rec_o.stamp, 100);
        chk("t3_hold",  trc_rec_o.stamp, 100);

        // full: push and pop together (cycle 120) must not drop
        wb_valid_i = 1; trc_ready_i = 1;
        tick();
        clr_in();
        chk("t4_drop", drop_cnt_o, 4);
        for (int i = 0; i < 15; i++) exp_stamp[i] = 32'd101 + 32'(i);
        exp_stamp[15] = 32'd120;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), trc_rec_o.stamp, exp_stamp[i]);
            tick();
        end
        trc_ready_i = 0;
        chk("t4_empty", trc_valid_o, 0);

        // tohost with 3 queued records: finish only after last pop
        for (int i = 0; i < 3; i++) begin
            wb_valid_i = 1; tick();
        end
        clr_in();
        dccm_wen_i = 1; dccm_waddr_i = 32'h1000_0000;
        tick(); clr_in();
        chk("t5_fin_q3", finish_o, 0);
        trc_ready_i = 1;
        tick(); chk("t5_fin_q2", finish_o, 0);
        tick(); chk("t5_fin_q1", finish_o, 0);
        tick(); chk("t5_fin", finish_o, 1);
        trc_ready_i = 0;
        wb_valid_i = 1; tick(); clr_in();
        chk("t5_postq", trc_valid_o, 1);
        chk("t5_stick", finish_o, 1);

        // reset mid-stream clears everything immediately
        #2 rst_n = 0;
        #1 chk_zero_outs("mid");
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("mid_disc", trc_valid_o, 0);

        // idle watchdog
        repeat (994) tick();
        chk("wd_early", hang_o, 0);
        repeat (12) tick();
`ifdef RETIRE_TRACE_WATCHDOG_EN
        chk("wd_hang", hang_o, 1);
`else
        chk("wd_hang", hang_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
